prime_sieve_stream: RTL and testbench

Parametrised Sieve of Eratosthenes engine with a runtime-selectable limit and bit-packed flag RAM. It streams every prime up to the limit through a valid/ready port, starting while sieving is still in progress. It replaces the fixed-size, timer-driven prime screen in the display path. The stream feeds the display/driver logic directly or through a FIFO.

---
 rtl/prime_pkg.sv | 36 +++
 rtl/flag_ram.sv | 27 ++
 rtl/prime_sieve_stream.sv | 257 +++++++++++++++++++++++++
 tb/tb_prime_sieve_stream.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// Shared types and flag-RAM addressing helpers for the prime sieve stream.
package prime_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_FIND_RD,
    S_FIND_WAIT,
    S_FIND_CHK,
    S_MARK_RD,
    S_MARK_WAIT,
    S_MARK_WR,
    S_SDONE
  } sieve_state_t;

  typedef enum logic [2:0] {
    O_WAIT,
    O_RD,
    O_RWAIT,
    O_CHK,
    O_HOLD
  } scan_state_t;

  localparam logic IS_PRIME  = 1'b0;
  localparam logic NOT_PRIME = 1'b1;

  // WORD_W is a power of two, so word/bit split is a shift and a mask.
  function automatic logic [31:0] word_addr(input logic [31:0] n, input int unsigned shift);
    return n >> shift;
  endfunction

  function automatic logic [31:0] bit_sel(input logic [31:0] n, input int unsigned word_w);
    return n & (word_w - 32'd1);
  endfunction

endpackage

// File: rtl/flag_ram.sv
// Simple dual-port flag RAM: one synchronous read port, one write port,
// read-during-write returns the old word.
module flag_ram
  import prime_pkg::*;
#(
  parameter int DEPTH  = 31250,
  parameter int WORD_W = 32,
  parameter int AW     = 15
) (
  input  logic              clk,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage write and registered read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/prime_sieve_stream.sv
// Sieve of Eratosthenes over a bit-packed flag RAM, streaming primes <= limit
// through valid/ready while the sieve is still running.
module prime_sieve_stream
  import prime_pkg::*;
#(
  parameter int N_MAX  = 999999,
  parameter int ADDR_W = 20,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] limit,
  output logic              busy,
  output logic              done,
  output logic              prime_valid,
  input  logic              prime_ready,
  output logic [ADDR_W-1:0] prime_data,
  output logic              prime_last,
  output logic [ADDR_W-1:0] prime_count
);

  localparam int DEPTH = (N_MAX + WORD_W) / WORD_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WSH   = $clog2(WORD_W);
  localparam int BW    = (WSH > 0) ? WSH : 1;
  localparam int DW    = 2 * ADDR_W;

  localparam logic [ADDR_W-1:0] N_MAX_V = ADDR_W'(N_MAX);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] A_TWO   = ADDR_W'(2'd2);
  localparam logic [ADDR_W:0]   I_ONE   = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W:0]   I_TWO   = (ADDR_W+1)'(2'd2);
  localparam logic [AW-1:0]     W_ONE_A = AW'(1'b1);
  localparam logic [WORD_W-1:0] W_ONE   = WORD_W'(1'b1);

  sieve_state_t      s_state;
  logic [ADDR_W-1:0] lim;
  logic [ADDR_W-1:0] p;
  logic [DW-1:0]     k;
  logic [AW-1:0]     clr;
  logic [WORD_W-1:0] s_word;

  scan_state_t       o_state;
  logic [ADDR_W:0]   i;
  logic              have;
  logic [ADDR_W-1:0] pend;
  logic [WORD_W-1:0] o_word;

  logic              arb_last;
  logic              s_req, o_req, gnt_s, gnt_o;
  logic              re, we;
  logic [AW-1:0]     raddr, waddr;
  logic [WORD_W-1:0] rdata, wdata;

  logic [DW-1:0]     pp, k_next;
  logic [AW-1:0]     p_word, k_word, i_word, lim_word;
  logic [BW-1:0]     p_bit, k_bit, i_bit;
  logic              i_gt_l, eligible, scan_fin;

  assign pp       = DW'(p) * DW'(p);
  assign k_next   = k + DW'(p);
  assign p_word   = AW'(word_addr(32'(p), WSH));
  assign k_word   = AW'(word_addr(32'(k), WSH));
  assign i_word   = AW'(word_addr(32'(i), WSH));
  assign lim_word = AW'(word_addr(32'(lim), WSH));
  assign p_bit    = BW'(bit_sel(32'(p), WORD_W));
  assign k_bit    = BW'(bit_sel(32'(k), WORD_W));
  assign i_bit    = BW'(bit_sel(32'(i), WORD_W));

  assign i_gt_l   = i > {1'b0, lim};
  // Flags below p are final; everything is final once the sieve is done.
  assign eligible = (i < {1'b0, p}) || (s_state == S_SDONE);
  assign scan_fin = ((o_state == O_HOLD) && prime_ready && prime_last) ||
                    ((o_state == O_WAIT) && !have && i_gt_l);

  // Round-robin read-port arbitration; the last grantee loses a tie.
  assign s_req = (s_state == S_FIND_RD) || (s_state == S_MARK_RD);
  assign o_req = (o_state == O_RD);
  assign gnt_s = s_req && (!o_req || arb_last);
  assign gnt_o = o_req && !gnt_s;
  assign re    = gnt_s || gnt_o;
  assign raddr = gnt_s ? ((s_state == S_FIND_RD) ? p_word : k_word) : i_word;

  // Write port: zero-fill during CLEAR, set bit k during MARK_WR.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if ((s_state == S_CLEAR) && (lim >= A_TWO)) begin
      we    = 1'b1;
      waddr = clr;
    end else if (s_state == S_MARK_WR) begin
      we    = 1'b1;
      waddr = k_word;
      wdata = s_word | (W_ONE << k_bit);
    end else begin
      we    = 1'b0;
    end
  end

  flag_ram #(.DEPTH(DEPTH), .WORD_W(WORD_W), .AW(AW)) u_ram (
    .clk   (clk),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  // Arbiter history.
  always_ff @(posedge clk) begin
    if (rst)        arb_last <= 1'b0;
    else if (gnt_s) arb_last <= 1'b0;
    else if (gnt_o) arb_last <= 1'b1;
  end

  // Sieve FSM with busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      lim     <= '0;
      p       <= '0;
      k       <= '0;
      clr     <= '0;
      s_word  <= '0;
    end else begin
      case (s_state)
        S_IDLE: begin
          if (start) begin
            lim     <= (limit > N_MAX_V) ? N_MAX_V : limit;
            p       <= A_TWO;
            clr     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            s_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (lim < A_TWO)           s_state <= S_SDONE;
          else if (clr == lim_word)  s_state <= S_FIND_RD;
          else                       clr <= clr + W_ONE_A;
        end
        S_FIND_RD:   if (gnt_s) s_state <= S_FIND_WAIT;
        S_FIND_WAIT: begin
          s_word  <= rdata;
          s_state <= S_FIND_CHK;
        end
        S_FIND_CHK: begin
          if (s_word[p_bit] == NOT_PRIME) begin
            p       <= p + A_ONE;
            s_state <= S_FIND_RD;
          end else if (pp > DW'(lim)) begin
            s_state <= S_SDONE;
          end else begin
            k       <= pp;
            s_state <= S_MARK_RD;
          end
        end
        S_MARK_RD:   if (gnt_s) s_state <= S_MARK_WAIT;
        S_MARK_WAIT: begin
          s_word  <= rdata;
          s_state <= S_MARK_WR;
        end
        S_MARK_WR: begin
          k <= k_next;
          if (k_next > DW'(lim)) begin
            p       <= p + A_ONE;
            s_state <= S_FIND_RD;
          end else begin
            s_state <= S_MARK_RD;
          end
        end
        S_SDONE: begin
          if (scan_fin) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            s_state <= S_IDLE;
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  // Output scanner. A found prime is held in pend until the next prime (or
  // the end of range) is seen, which is what decides prime_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_state     <= O_WAIT;
      i           <= I_TWO;
      have        <= 1'b0;
      pend        <= '0;
      o_word      <= '0;
      prime_valid <= 1'b0;
      prime_data  <= '0;
      prime_last  <= 1'b0;
      prime_count <= '0;
    end else if ((s_state == S_IDLE) && start) begin
      o_state     <= O_WAIT;
      i           <= I_TWO;
      have        <= 1'b0;
      pend        <= '0;
      prime_valid <= 1'b0;
      prime_data  <= '0;
      prime_last  <= 1'b0;
      prime_count <= '0;
    end else if (busy) begin
      case (o_state)
        O_WAIT: begin
          if (i_gt_l) begin
            if (have) begin
              prime_valid <= 1'b1;
              prime_data  <= pend;
              prime_last  <= 1'b1;
              have        <= 1'b0;
              o_state     <= O_HOLD;
            end
          end else if (eligible) begin
            o_state <= O_RD;
          end
        end
        O_RD:    if (gnt_o) o_state <= O_RWAIT;
        O_RWAIT: begin
          o_word  <= rdata;
          o_state <= O_CHK;
        end
        O_CHK: begin
          i       <= i + I_ONE;
          o_state <= O_WAIT;
          if (o_word[i_bit] == IS_PRIME) begin
            pend <= i[ADDR_W-1:0];
            have <= 1'b1;
            if (have) begin
              prime_valid <= 1'b1;
              prime_data  <= pend;
              prime_last  <= 1'b0;
              o_state     <= O_HOLD;
            end
          end
        end
        O_HOLD: begin
          if (prime_ready) begin
            prime_valid <= 1'b0;
            prime_count <= prime_count + A_ONE;
            o_state     <= O_WAIT;
          end
        end
        default: o_state <= O_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_sieve_stream.sv
// Randomised stream bench for prime_sieve_stream against a trial-division model.
module tb_prime_sieve_stream;

  localparam int NMAX = 999;
  localparam int AW   = 20;

  logic          clk = 1'b0;
  logic          rst, start, prime_ready;
  logic [AW-1:0] limit;
  logic          busy, done, prime_valid, prime_last;
  logic [AW-1:0] prime_data, prime_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int idx = 0;
  bit chk_en = 1'b0;
  int duty = 100;
  bit prev_stall = 1'b0;
  int prev_data = 0;
  bit prev_last = 1'b0;
  int last_seen = -1;
  int lit30[10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};

  prime_sieve_stream #(.N_MAX(NMAX), .ADDR_W(AW), .WORD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .limit       (limit),
    .busy        (busy),
    .done        (done),
    .prime_valid (prime_valid),
    .prime_ready (prime_ready),
    .prime_data  (prime_data),
    .prime_last  (prime_last),
    .prime_count (prime_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void build_exp(input int l);
    int lc;
    lc = (l > NMAX) ? NMAX : l;
    exp_q.delete();
    for (int n = 2; n <= lc; n++)
      if (is_prime(n)) exp_q.push_back(n);
  endfunction

  // Per-cycle comparison of the stream against the model list.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", int'(prime_count), idx);
      if (exp_q.size() > 0) begin
        check("done", int'(done), int'(idx == exp_q.size()));
        check("busy", int'(busy), int'(idx != exp_q.size()));
      end
      if (prev_stall) begin
        check("hold_valid", int'(prime_valid), 1);
        check("hold_data", int'(prime_data), prev_data);
        check("hold_last", int'(prime_last), int'(prev_last));
      end
      if (prime_valid && prime_ready) begin
        check("data", int'(prime_data), (idx < exp_q.size()) ? exp_q[idx] : -1);
        check("last", int'(prime_last), int'(idx == exp_q.size() - 1));
        if (prime_last) last_seen = int'(prime_data);
        idx++;
      end
      prev_stall = prime_valid && !prime_ready;
      prev_data  = int'(prime_data);
      prev_last  = prime_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    prime_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      prime_ready = (int'($urandom_range(99, 0)) < duty);
    end
  end

  task automatic start_run(input int l, input int d);
    @(posedge clk);
    #1;
    build_exp(l);
    idx = 0;
    last_seen = -1;
    duty = d;
    start = 1'b1;
    limit = AW'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("done_after_start", int'(done), 0);
    prev_stall = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!done && c < 40000) begin
      @(negedge clk);
      c++;
    end
    check("done_timeout", int'(done), 1);
    @(negedge clk);
    chk_en = 1'b0;
    check("final_count", int'(prime_count), exp_q.size());
    check("beats", idx, exp_q.size());
  endtask

  task automatic run(input int l, input int d);
    start_run(l, d);
    wait_done();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_valid"}, int'(prime_valid), 0);
    check({tag, "_data"}, int'(prime_data), 0);
    check({tag, "_last"}, int'(prime_last), 0);
    check({tag, "_count"}, int'(prime_count), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    limit = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Hand-computed values that pin the model.
    build_exp(30);
    check("model30_size", exp_q.size(), 10);
    for (int j = 0; j < 10; j++) check("model30_val", exp_q[j], lit30[j]);
    build_exp(100);
    check("model100_size", exp_q.size(), 25);
    build_exp(200);
    check("model200_size", exp_q.size(), 46);
    build_exp(1048575);
    check("model_clip_size", exp_q.size(), 168);
    check("model_clip_last", exp_q[exp_q.size() - 1], 997);

    run(30, 100);
    check("last30", last_seen, 29);
    check("done30", int'(done), 1);
    run(1, 100);
    run(0, 100);
    check("done0", int'(done), 1);
    run(2, 100);
    check("last2", last_seen, 2);
    run(100, 30);
    check("last100", last_seen, 97);

    // A second start during a run must be ignored.
    start_run(200, 60);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1;
    limit = AW'(50);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    check("last_busy_start", last_seen, 199);

    // Reset in the middle of marking, then a fresh short run.
    start_run(1000, 100);
    repeat (120) @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("midreset");
    rst = 1'b0;
    run(50, 50);
    check("count50", int'(prime_count), 15);
    check("last50", last_seen, 47);

    run(1048575, 70);
    check("last_clip", last_seen, 997);

    for (int r = 0; r < 3; r++) begin
      run(int'($urandom_range(400, 3)), int'($urandom_range(100, 20)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
